// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Result lands WIDTH+1 edges after start with a one-cycle done; start ignored while busy.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             r_state, w_next;
   logic               r_is_div, r_neg_q, r_neg_r, r_dz;
   logic               r_done, r_div_zero;
   logic [WIDTH-1:0]   r_b, r_rem, r_q, r_hi, r_lo;
   logic [CW-1:0]      r_cnt;

   logic               w_accept, w_fire, w_signed, w_neg_a, w_neg_b;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_mul_sum, w_shift, w_trial;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

   assign w_signed = ~op[0];
   assign w_neg_a  = w_signed & src_a[WIDTH-1];
   assign w_neg_b  = w_signed & src_b[WIDTH-1];
   assign w_abs_a  = w_neg_a ? -src_a : src_a;
   assign w_abs_b  = w_neg_b ? -src_b : src_b;

   // r_rem/r_q double as {product high, multiplier} for mul and {remainder, dividend} for div.
   assign w_mul_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : '0);
   assign w_shift   = {r_rem, r_q[WIDTH-1]};
   assign w_trial   = w_shift - {1'b0, r_b};

   assign w_prod     = {r_rem, r_q};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo_fix  = r_neg_q ? -r_q : r_q;
   assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_fire   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !cancel) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            if (cancel)                   w_next = S_IDLE;
            else if (r_cnt == CW'(1))     w_next = S_FIX;
         end
         S_FIX: begin
            w_fire = ~cancel;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_b        <= '0;
         r_rem      <= '0;
         r_q        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_next;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         if (wr_hi) r_hi <= wr_data;
         if (wr_lo) r_lo <= wr_data;

         if (w_accept) begin
            r_is_div <= op[1];
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_dz     <= op[1] && (src_b == '0);
            r_rem    <= '0;
            r_q      <= op[1] ? w_abs_a : w_abs_b;
            r_b      <= op[1] ? w_abs_b : w_abs_a;
            r_cnt    <= CW'(WIDTH);
         end

         if (r_state == S_RUN && !cancel) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_is_div) begin
               r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
               r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            end else begin
               r_rem <= w_mul_sum[WIDTH:1];
               r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
         end

         // Result write overrides a same-edge MTHI/MTLO; divide-by-zero leaves HI/LO alone.
         if (w_fire) begin
            r_done     <= 1'b1;
            r_div_zero <= r_dz;
            if (!r_is_div) begin
               r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
               r_lo <= w_prod_fix[WIDTH-1:0];
            end else if (!r_dz) begin
               r_hi <= w_rem_fix;
               r_lo <= w_quo_fix;
            end
         end
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, control corner sequences,
// and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, cancel, wr_hi, wr_lo;
   logic [1:0]   op;
   logic [W-1:0] src_a, src_b, wr_data;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [W-1:0] m_hi = '0, m_lo = '0;   // architectural HI/LO as the bench expects them

   int           g_dk, g_nd, g_nb, g_busy_after;
   logic [W-1:0] g_hi, g_lo;
   logic         g_dz;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, ehi, elo;
      logic         edz;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] ohi, input logic [W-1:0] olo,
                                 output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic edz);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ehi = ohi; elo = olo; edz = 1'b0;
      case (o)
         2'd0: begin sp = sa * sb; {ehi, elo} = sp; end
         2'd1: begin up = ua * ub; {ehi, elo} = up; end
         2'd2: begin
            if (b == '0) edz = 1'b1;
            else begin sq = sa / sb; sr = sa % sb; elo = sq[W-1:0]; ehi = sr[W-1:0]; end
         end
         default: begin
            if (b == '0) edz = 1'b1;
            else begin uq = ua / ub; ur = ua % ub; elo = uq[W-1:0]; ehi = ur[W-1:0]; end
         end
      endcase
   endfunction

   // kind: 0 none, 1 re-start, 2 cancel, 3 rst, 4 wr_lo; injected so that edge E0+at samples it.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int kind, input int at, input bit imm);
      if (!imm) @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      g_dk = -1; g_nd = 0; g_nb = 0; g_busy_after = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy) g_nb++;
         if (k == at + 1) g_busy_after = int'(busy);
         if (done) begin
            g_nd++;
            if (g_dk < 0) g_dk = k;
            g_hi = hi; g_lo = lo; g_dz = div_zero;
         end
         start = 1'b0; cancel = 1'b0; rst = 1'b0; wr_lo = 1'b0;
         op = 2'($urandom); src_a = $urandom; src_b = $urandom;
         if (done) break;
         if (k == at) begin
            case (kind)
               1: start = 1'b1;
               2: cancel = 1'b1;
               3: rst = 1'b1;
               4: begin wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF; end
               default: ;
            endcase
         end
      end
   endtask

   logic [W-1:0] e_hi, e_lo, ra, rb;
   logic         e_dz;
   logic [1:0]   ro;
   bit           seen;

   initial begin
      rst = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      op = '0; src_a = '0; src_b = '0; wr_data = '0;

      tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      tbl[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      tbl[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      tbl[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      tbl[4]  = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      tbl[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      tbl[6]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      tbl[7]  = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      tbl[8]  = '{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
      tbl[9]  = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      tbl[10] = '{2'd2, 32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000, 1'b0};
      tbl[11] = '{2'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
      tbl[12] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      tbl[13] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      tbl[14] = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz",   64'(div_zero), 64'd0);
      chk("rst_hi",   64'(hi), 64'd0);
      chk("rst_lo",   64'(lo), 64'd0);

      // Directed vectors with full handshake timing
      for (int i = 0; i < 15; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, 1'b0);
         chk($sformatf("tbl%0d_done_cycle", i), 64'(g_dk), 64'd34);
         chk($sformatf("tbl%0d_busy_cycles", i), 64'(g_nb), 64'd33);
         chk($sformatf("tbl%0d_hi", i), 64'(g_hi), 64'(tbl[i].ehi));
         chk($sformatf("tbl%0d_lo", i), 64'(g_lo), 64'(tbl[i].elo));
         chk($sformatf("tbl%0d_dz", i), 64'(g_dz), 64'(tbl[i].edz));
         m_hi = tbl[i].ehi; m_lo = tbl[i].elo;
      end

      // MTHI then divide by zero: HI/LO untouched
      @(negedge clk); wr_hi = 1'b1; wr_data = 32'h0000_1234;
      @(negedge clk); wr_hi = 1'b0;
      chk("mthi_hi", 64'(hi), 64'h1234);
      m_hi = 32'h1234;
      run_op(2'd3, 32'd9, 32'd0, 0, 0, 1'b0);
      chk("dz_done_cycle", 64'(g_dk), 64'd34);
      chk("dz_flag", 64'(g_dz), 64'd1);
      chk("dz_hi", 64'(g_hi), 64'(m_hi));
      chk("dz_lo", 64'(g_lo), 64'(m_lo));
      @(negedge clk);
      chk("dz_flag_clears", 64'(div_zero), 64'd0);

      // Second start mid-op is ignored
      run_op(2'd1, 32'd6, 32'd7, 1, 5, 1'b0);
      chk("restart_done_cycle", 64'(g_dk), 64'd34);
      chk("restart_lo", 64'(g_lo), 64'd42);
      chk("restart_hi", 64'(g_hi), 64'd0);
      m_hi = 32'd0; m_lo = 32'd42;
      repeat (10) @(negedge clk);
      chk("restart_no_second", 64'(busy | done), 64'd0);

      // Cancel mid-op
      run_op(2'd0, 32'h0000_0123, 32'hFFFF_FF00, 2, 10, 1'b0);
      chk("cancel_busy_next", 64'(g_busy_after), 64'd0);
      chk("cancel_no_done", 64'(g_nd), 64'd0);
      chk("cancel_hi", 64'(hi), 64'(m_hi));
      chk("cancel_lo", 64'(lo), 64'(m_lo));

      // Reset mid-op
      run_op(2'd2, 32'h0000_0100, 32'd3, 3, 10, 1'b0);
      chk("rst_mid_busy", 64'(g_busy_after), 64'd0);
      chk("rst_mid_no_done", 64'(g_nd), 64'd0);
      chk("rst_mid_hi", 64'(hi), 64'd0);
      chk("rst_mid_lo", 64'(lo), 64'd0);
      m_hi = '0; m_lo = '0;

      // cancel together with start in IDLE drops the start
      @(negedge clk); start = 1'b1; cancel = 1'b1; op = 2'd1; src_a = 32'd5; src_b = 32'd5;
      @(negedge clk); start = 1'b0; cancel = 1'b0;
      chk("cancel_start_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      chk("cancel_start_lo", 64'(lo), 64'(m_lo));

      // MTHI together with start: write lands and op is accepted
      @(negedge clk); start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3;
      wr_hi = 1'b1; wr_data = 32'h0000_ABCD;
      @(negedge clk); start = 1'b0; wr_hi = 1'b0;
      chk("wr_start_hi", 64'(hi), 64'hABCD);
      chk("wr_start_busy", 64'(busy), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("wr_start_done_seen", 64'(seen), 64'd1);
      chk("wr_start_res_hi", 64'(hi), 64'd0);
      chk("wr_start_res_lo", 64'(lo), 64'd6);

      // Back-to-back: start in done cycle, MTLO on second op's FIX edge loses to the result
      run_op(2'd1, 32'd3, 32'd4, 0, 0, 1'b0);
      chk("b2b_first_lo", 64'(g_lo), 64'd12);
      run_op(2'd3, 32'd100, 32'd7, 4, 33, 1'b1);
      chk("b2b_done_cycle", 64'(g_dk), 64'd34);
      chk("b2b_lo", 64'(g_lo), 64'd14);
      chk("b2b_hi", 64'(g_hi), 64'd2);
      m_hi = 32'd2; m_lo = 32'd14;

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         model(ro, ra, rb, m_hi, m_lo, e_hi, e_lo, e_dz);
         run_op(ro, ra, rb, 0, 0, 1'b0);
         chk($sformatf("rnd%0d_done_cycle", i), 64'(g_dk), 64'd34);
         chk($sformatf("rnd%0d_op%0d_hi a=%h b=%h", i, ro, ra, rb), 64'(g_hi), 64'(e_hi));
         chk($sformatf("rnd%0d_op%0d_lo a=%h b=%h", i, ro, ra, rb), 64'(g_lo), 64'(e_lo));
         chk($sformatf("rnd%0d_dz", i), 64'(g_dz), 64'(e_dz));
         m_hi = e_hi; m_lo = e_lo;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
